// File: rtl/seg16_pkg.sv
// Shared constants for the 16-segment loopback decoder: code table, blank code,
// segment bit indices, FSM state type and the table lookup helper.
package seg16_pkg;

    localparam int unsigned SEG_A1 = 0;
    localparam int unsigned SEG_A2 = 1;
    localparam int unsigned SEG_B  = 2;
    localparam int unsigned SEG_C  = 3;
    localparam int unsigned SEG_D1 = 4;
    localparam int unsigned SEG_D2 = 5;
    localparam int unsigned SEG_E  = 6;
    localparam int unsigned SEG_F  = 7;
    localparam int unsigned SEG_G1 = 8;
    localparam int unsigned SEG_G2 = 9;
    localparam int unsigned SEG_H  = 10;
    localparam int unsigned SEG_I  = 11;
    localparam int unsigned SEG_J  = 12;
    localparam int unsigned SEG_K  = 13;
    localparam int unsigned SEG_L  = 14;
    localparam int unsigned SEG_M  = 15;

    localparam logic [15:0] SEG16_BLANK = 16'h0000;

    localparam logic [15:0] SEG16_CODE [0:15] = '{
        16'h00FF, 16'h000C, 16'h0377, 16'h033F,
        16'h038C, 16'h03BB, 16'h03FB, 16'h000F,
        16'h03FF, 16'h03BF, 16'h03CF, 16'h4A3F,
        16'h00F3, 16'h483F, 16'h01F3, 16'h01C3
    };

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } seg16_state_t;

    // Returns {hit, digit}; exact match only.
    function automatic logic [4:0] seg16_lookup(input logic [15:0] pat);
        logic [4:0] res;
        res = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (pat == SEG16_CODE[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg16_sync2_vec.sv
// Two-flop synchronizer for a vector of independent asynchronous lines.
module sync2_vec #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/seg16_decoder.sv
// Decodes a stable 16-segment pattern back to a hex digit and tracks count direction.
// Step/direction tracking is built only when SEG16_STEP_CHECK_EN is defined.
module seg16_decoder
    import seg16_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seg_in,
    output logic [3:0]  value,
    output logic        valid,
    output logic        blank,
    output logic        code_err,
    output logic        dir_up,
    output logic        step_err
);

    logic [15:0]  w_sync;
    logic [15:0]  r_cmp;
    logic [CNT_W-1:0] r_cnt;
    logic         w_diff;
    int unsigned  w_samples;
    logic         w_accept;
    logic [4:0]   w_lookup;
    logic         w_hit;
    logic [3:0]   w_digit;

    seg16_state_t r_state;
    seg16_state_t w_state_nxt;

    logic [3:0]   r_value;
    logic         r_valid;
    logic         r_blank;
    logic         r_code_err;

    sync2_vec #(.WIDTH(16)) u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (seg_in),
        .o_q (w_sync)
    );

    assign w_diff = (w_sync != r_cmp);

    // Samples of the current pattern including this one; r_cmp itself is the first.
    always_comb begin
        w_samples = 32'd1;
        if (!w_diff) begin
            w_samples = 32'(r_cnt) + 32'd2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmp <= '0;
            r_cnt <= '0;
        end else begin
            r_cmp <= w_sync;
            if (w_diff) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_W'(STABLE_CYCLES)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SETTLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            SETTLE: begin
                if (w_samples >= STABLE_CYCLES) begin
                    w_accept    = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_diff) begin
                    // With a one-sample threshold the changed sample is already stable.
                    if (w_samples >= STABLE_CYCLES) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_nxt = SETTLE;
                    end
                end
            end
            default: w_state_nxt = SETTLE;
        endcase
    end

    assign w_lookup = seg16_lookup(w_sync);
    assign w_hit    = w_lookup[4];
    assign w_digit  = w_lookup[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value    <= '0;
            r_valid    <= 1'b0;
            r_blank    <= 1'b1;
            r_code_err <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_code_err <= 1'b0;
            if (w_accept) begin
                if (w_hit) begin
                    r_value <= w_digit;
                    r_valid <= 1'b1;
                    r_blank <= 1'b0;
                end else if (w_sync == SEG16_BLANK) begin
                    r_blank <= 1'b1;
                end else begin
                    r_code_err <= 1'b1;
                end
            end
        end
    end

`ifdef SEG16_STEP_CHECK_EN
    logic [3:0] r_prev;
    logic       r_have_prev;
    logic       r_dir_up;
    logic       r_step_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_dir_up    <= 1'b0;
            r_step_err  <= 1'b0;
        end else begin
            r_step_err <= 1'b0;
            if (w_accept && w_hit) begin
                r_prev      <= w_digit;
                r_have_prev <= 1'b1;
                if (r_have_prev) begin
                    if (w_digit == r_prev + 4'd1) begin
                        r_dir_up <= 1'b1;
                    end else if (w_digit == r_prev - 4'd1) begin
                        r_dir_up <= 1'b0;
                    end else if (w_digit != r_prev) begin
                        r_step_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign dir_up   = r_dir_up;
    assign step_err = r_step_err;
`else
    assign dir_up   = 1'b0;
    assign step_err = 1'b0;
`endif

    assign value    = r_value;
    assign valid    = r_valid;
    assign blank    = r_blank;
    assign code_err = r_code_err;

endmodule

// File: tb/tb_seg16_decoder.sv
// Directed self-checking bench for seg16_decoder (STABLE_CYCLES=4).
module tb_seg16_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] seg_in;
    logic [3:0]  value;
    logic        valid;
    logic        blank;
    logic        code_err;
    logic        dir_up;
    logic        step_err;

`ifdef SEG16_STEP_CHECK_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int n_valid;
    int n_cerr;
    int n_serr;
    int first_valid;
    int first_serr;

    always #5 clk = ~clk;

    seg16_decoder #(.STABLE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .seg_in   (seg_in),
        .value    (value),
        .valid    (valid),
        .blank    (blank),
        .code_err (code_err),
        .dir_up   (dir_up),
        .step_err (step_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drives a pattern at a falling edge and tallies pulses seen on each following falling edge.
    task automatic hold(input logic [15:0] pat, input int cycles);
        seg_in      = pat;
        n_valid     = 0;
        n_cerr      = 0;
        n_serr      = 0;
        first_valid = 0;
        first_serr  = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n_valid++;
                if (first_valid == 0) first_valid = i;
            end
            if (code_err === 1'b1) n_cerr++;
            if (step_err === 1'b1) begin
                n_serr++;
                if (first_serr == 0) first_serr = i;
            end
        end
    endtask

    task automatic pulse_reset(input logic [15:0] pat);
        seg_in = pat;
        reset  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        seg_in = 16'h0000;
        #1;
        check("reset_outputs", {23'd0, value, valid, blank, code_err, dir_up, step_err}, 32'h008);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        hold(16'h0000, 10);
        check("blank_no_valid", n_valid, 0);
        check("blank_level", blank, 1);
        check("blank_value", value, 0);

        hold(16'h033F, 8);
        check("d3_valid_count", n_valid, 1);
        check("d3_latency", first_valid, 6);
        check("d3_value", value, 3);
        check("d3_blank", blank, 0);
        check("d3_no_cerr", n_cerr, 0);

        pulse_reset(16'h0000);
        hold(16'h0000, 4);

        hold(16'h03FF, 8);
        check("d8_valid", n_valid, 1);
        check("d8_value", value, 8);
        check("d8_dir_first", dir_up, 0);
        check("d8_no_serr", n_serr, 0);
        hold(16'h03BF, 8);
        check("d9_value", value, 9);
        check("d9_dir_up", dir_up, STEP_EN ? 1 : 0);
        check("d9_no_serr", n_serr, 0);
        hold(16'h03CF, 8);
        check("dA_value", value, 10);
        check("dA_valid", n_valid, 1);
        check("dA_no_serr", n_serr, 0);

        hold(16'h0000, 8);
        check("blank2_level", blank, 1);
        check("blank2_no_valid", n_valid, 0);
        check("blank2_value_held", value, 10);
        hold(16'h00FF, 8);
        check("d0_value", value, 0);
        check("d0_blank_clr", blank, 0);
        check("d0_serr_from_A", n_serr, STEP_EN ? 1 : 0);
        check("d0_dir_held", dir_up, STEP_EN ? 1 : 0);
        hold(16'h01C3, 8);
        check("dF_value", value, 15);
        check("dF_wrap_down", dir_up, 0);
        check("dF_no_serr", n_serr, 0);
        hold(16'h033F, 8);
        check("d3b_value", value, 3);
        check("d3b_serr", n_serr, STEP_EN ? 1 : 0);
        check("d3b_serr_with_valid", first_serr, STEP_EN ? first_valid : 0);
        check("d3b_dir_held", dir_up, 0);
        hold(16'h01C3, 8);
        check("dF2_serr", n_serr, STEP_EN ? 1 : 0);
        hold(16'h00FF, 8);
        check("d0b_wrap_up", dir_up, STEP_EN ? 1 : 0);
        check("d0b_no_serr", n_serr, 0);

        hold(16'h1234, 8);
        check("bad_cerr", n_cerr, 1);
        check("bad_no_valid", n_valid, 0);
        check("bad_value_held", value, 0);
        check("bad_blank_held", blank, 0);
        hold(16'h000C, 2);
        check("glitch_no_valid", n_valid, 0);
        check("glitch_no_cerr", n_cerr, 0);
        hold(16'h1234, 3);
        check("post_glitch_quiet", n_valid + n_cerr, 0);
        hold(16'h1234, 8);
        check("post_glitch_resettle", n_cerr, 1);
        check("post_glitch_value", value, 0);

        hold(16'h000F, 2);
        seg_in = 16'h000F;
        reset  = 1'b1;
        #1;
        check("midreset_value", value, 0);
        check("midreset_blank", blank, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold(16'h000F, 8);
        check("d7_latency", first_valid, 6);
        check("d7_valid_count", n_valid, 1);
        check("d7_value", value, 7);
        check("d7_no_serr", n_serr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
